// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants: frame FSM states, prefix bytes, frame geometry.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0]  PS2_BREAK     = 8'hF0;
  localparam logic [7:0]  PS2_EXT       = 8'hE0;
  localparam int unsigned PS2_FRAME_LEN = 11;
  // Start, parity and stop bits surround the data byte.
  localparam int unsigned PS2_DATA_BITS = PS2_FRAME_LEN - 3;

endpackage

// File: rtl/ps2_sync_filter.sv
// 2-FF synchronizer followed by a glitch filter; the filtered level changes only after the
// synchronized input holds a new value for FILTER_LEN cycles. o_fall pulses on a filtered 1->0.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_sync,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sync  = r_sync[1];
  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserializes 11-bit frames into scan codes and tracks the held key
// through make/break/extended prefixes.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_down
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic w_strobe, w_clk_sync, w_clk_level;
  logic w_data, w_data_level, w_data_fall;
  logic w_unused;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset_n(reset_n), .i_raw(ps2_clk),
    .o_sync(w_clk_sync), .o_level(w_clk_level), .o_fall(w_strobe)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .reset_n(reset_n), .i_raw(ps2_data),
    .o_sync(w_data), .o_level(w_data_level), .o_fall(w_data_fall)
  );

  assign w_unused = &{1'b0, w_clk_sync, w_clk_level, w_data_level, w_data_fall};

  ps2_state_e       r_state, w_next;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_par_ok;
  logic [TMO_W-1:0] r_tmo;
  logic [7:0]       r_code, r_key_code;
  logic             r_code_valid, r_frame_err, r_key_down, r_brk, r_ext;
  logic             w_timeout, w_valid_c, w_err_c;

  // A strobe in the same cycle as the limit wins over the timeout.
  assign w_timeout = (r_state != ST_IDLE) && !w_strobe && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_strobe && !w_data) w_next = ST_DATA;
      ST_DATA:   if (w_strobe && r_bit_cnt == 3'(PS2_DATA_BITS - 1)) w_next = ST_PARITY;
      ST_PARITY: if (w_strobe) w_next = ST_STOP;
      ST_STOP:   if (w_strobe) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_IDLE;
  end

  always_comb begin
    w_valid_c = 1'b0;
    w_err_c   = w_timeout;
    if (w_strobe) begin
      case (r_state)
        ST_IDLE: w_err_c = w_data;
        ST_STOP: begin
          w_valid_c = w_data && r_par_ok;
          w_err_c   = !(w_data && r_par_ok);
        end
        default: ;
      endcase
    end
  end

  // Frame datapath: shift register, bit counter, parity, idle timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par_ok     <= 1'b0;
      r_tmo        <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_strobe || r_state == ST_IDLE || w_timeout) r_tmo <= '0;
      else                                            r_tmo <= r_tmo + TMO_W'(1);
      if (w_strobe) begin
        case (r_state)
          ST_IDLE:   r_bit_cnt <= '0;
          ST_DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'(1);
          end
          ST_PARITY: r_par_ok <= ^{r_shift, w_data};
          default: ;
        endcase
      end
      r_code_valid <= w_valid_c;
      r_frame_err  <= w_err_c;
      if (w_valid_c) r_code <= r_shift;
    end
  end

  // Held-key tracker driven by accepted bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_code <= '0;
      r_key_down <= 1'b0;
      r_brk      <= 1'b0;
      r_ext      <= 1'b0;
    end else if (r_code_valid) begin
      if (r_code == PS2_BREAK) begin
        r_brk <= 1'b1;
      end else if (r_code == PS2_EXT) begin
        r_ext <= 1'b1;
      end else begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
        if (!r_ext) begin
          if (r_brk) begin
            if (r_code == r_key_code) begin
              r_key_code <= '0;
              r_key_down <= 1'b0;
            end
          end else begin
            r_key_code <= r_code;
            r_key_down <= 1'b1;
          end
        end
      end
    end else if (r_frame_err) begin
      r_brk <= 1'b0;
      r_ext <= 1'b0;
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign frame_err  = r_frame_err;
  assign key_code   = r_key_code;
  assign key_down   = r_key_down;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: frame vector table with a scoreboard of expected
// code/error events, plus timeout, glitch, bad-start and mid-frame reset sequences.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int HALF = 20;

  logic       clk, reset_n, ps2_clk, ps2_data;
  logic [7:0] code, key_code;
  logic       code_valid, frame_err, key_down;

  ps2_keyboard_rx dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .frame_err(frame_err),
    .key_code(key_code), .key_down(key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         exp_err;
    logic [7:0] exp_key;
    bit         exp_down;
  } vec_t;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;
  bit   prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, evaluated once per cycle on the falling edge.
  task automatic mon();
    exp_t e;
    if (code_valid && frame_err) chk("valid_err_overlap", 32'(frame_err), 32'(0));
    if (code_valid && prev_valid) chk("valid_one_cycle", 32'(prev_valid), 32'(0));
    if (code_valid || frame_err) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: valid=%0b err=%0b code=%0h", code_valid, frame_err, code);
      end else begin
        e = sb_q.pop_front();
        chk("event_is_err", 32'(frame_err), 32'(e.is_err));
        if (!e.is_err) chk("code", 32'(code), 32'(e.code));
      end
    end
    prev_valid = code_valid;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mon();
    end
  endtask

  task automatic send_bit(input bit b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      tick(6);
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(HALF - 8);
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit glitch);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], glitch);
  endtask

  task automatic push(input bit is_err, input logic [7:0] c);
    exp_t e;
    e.is_err = is_err;
    e.code   = c;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && sb_q.size() > 0; i++) tick(1);
    checks++;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL %s: %0d expected events still pending after %0d cycles", name, sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  task automatic chk_key(input string name, input logic [7:0] k, input bit d);
    tick(3);
    chk({name, "_key_code"}, 32'(key_code), 32'(k));
    chk({name, "_key_down"}, 32'(key_down), 32'(d));
  endtask

  initial begin
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b1};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 8'h1C, 1'b1};
    vecs[2]  = '{8'h1C, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b1};
    vecs[4]  = '{8'h1B, 1'b0, 1'b0, 8'h1B, 1'b1};
    vecs[5]  = '{8'hF0, 1'b0, 1'b0, 8'h1B, 1'b1};
    vecs[6]  = '{8'h1C, 1'b0, 1'b0, 8'h1B, 1'b1};
    vecs[7]  = '{8'h1C, 1'b1, 1'b1, 8'h1B, 1'b1};
    vecs[8]  = '{8'hE0, 1'b0, 1'b0, 8'h1B, 1'b1};
    vecs[9]  = '{8'h75, 1'b0, 1'b0, 8'h1B, 1'b1};
    vecs[10] = '{8'h1B, 1'b0, 1'b0, 8'h1B, 1'b1};
    vecs[11] = '{8'hF0, 1'b0, 1'b0, 8'h1B, 1'b1};
    vecs[12] = '{8'h1B, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{8'h1D, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[15] = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b1};

    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(3);
    chk("rst_code", 32'(code), 32'(0));
    chk("rst_code_valid", 32'(code_valid), 32'(0));
    chk("rst_frame_err", 32'(frame_err), 32'(0));
    chk("rst_key_code", 32'(key_code), 32'(0));
    chk("rst_key_down", 32'(key_down), 32'(0));
    reset_n = 1'b1;
    tick(20);

    for (int v = 0; v < 16; v++) begin
      push(vecs[v].exp_err, vecs[v].data);
      send_frame(vecs[v].data, vecs[v].bad_par, 1'b0);
      drain($sformatf("vec%0d_drain", v), 200);
      chk_key($sformatf("vec%0d", v), vecs[v].exp_key, vecs[v].exp_down);
    end

    // Clock stalls after four data bits; the frame must be aborted by timeout.
    push(1'b1, 8'h00);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    drain("timeout_drain", 52000);
    chk("timeout_idle", 32'(dut.r_state), 32'(ST_IDLE));
    chk_key("timeout", 8'h1C, 1'b1);

    push(1'b0, 8'h23);
    send_frame(8'h23, 1'b0, 1'b0);
    drain("after_tmo_drain", 200);
    chk_key("after_tmo", 8'h23, 1'b1);

    push(1'b0, 8'h2B);
    send_frame(8'h2B, 1'b0, 1'b1);
    drain("glitch_drain", 200);
    chk_key("glitch", 8'h2B, 1'b1);

    push(1'b1, 8'h00);
    send_bit(1'b1, 1'b0);
    drain("bad_start_drain", 200);
    chk_key("bad_start", 8'h2B, 1'b1);

    // Reset in the middle of a frame clears everything immediately.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    tick(1);
    chk("midrst_code", 32'(code), 32'(0));
    chk("midrst_frame_err", 32'(frame_err), 32'(0));
    chk("midrst_key_code", 32'(key_code), 32'(0));
    chk("midrst_key_down", 32'(key_down), 32'(0));
    chk("midrst_state", 32'(dut.r_state), 32'(ST_IDLE));
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(20);

    push(1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    drain("post_rst_drain", 200);
    chk_key("post_rst", 8'h1C, 1'b1);

    tick(50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
